// File: rtl/imem_loader_if.sv
// Program-load stream, loader status and fetch read port of the SPU instruction memory.
// The loader side uses the slave modport and the host/fetch side uses the master modport.
interface imem_loader_if #(
  parameter int WORD = 32
);
  logic                ld_start;
  logic [9:0]          ld_len;
  logic                ld_valid;
  logic [0:WORD-1]     ld_data;
  logic                ld_ready;
  logic                ld_busy;
  logic                ld_done;
  logic                ld_error;
  logic                fetch_hold;
  logic [0:WORD-1]     rd_addr;
  logic [0:2*WORD-1]   rd_data;

  modport master (
    output ld_start, ld_len, ld_valid, ld_data, rd_addr,
    input  ld_ready, ld_busy, ld_done, ld_error, fetch_hold, rd_data
  );

  modport slave (
    input  ld_start, ld_len, ld_valid, ld_data, rd_addr,
    output ld_ready, ld_busy, ld_done, ld_error, fetch_hold, rd_data
  );
endinterface

// File: rtl/imem_loader.sv
// Streams a program big-endian into the byte-addressed IMEM and serves the 8-byte fetch port.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after each program.
module imem_loader #(
  parameter int WORD       = 32,
  parameter int IMEM_BYTES = 2048
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);
  localparam int         AW  = $clog2(IMEM_BYTES);
  localparam int         PW  = AW - 2;
  localparam logic [9:0] CAP = 10'(IMEM_BYTES / 4);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t            state_r;
  state_t            next_state_s;
  logic [PW-1:0]     ptr_r;
  logic [9:0]        len_r;
  logic [7:0]        mem_r [0:IMEM_BYTES-1];
  logic              start_ok_s;
  logic              start_bad_s;
  logic              hs_s;
  logic              last_s;
  logic              err_s;
  logic              ready_s, busy_s, done_s, hold_s;
  logic              ready_r, busy_r, done_r, hold_r, error_r;
  logic [AW-1:0]     rd_base_s;
  logic [0:2*WORD-1] rd_s;
  logic              unused_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [0:WORD-1]   xor_r;
`endif

  assign start_ok_s  = bus.ld_start && (bus.ld_len != 10'd0) && (bus.ld_len <= CAP);
  assign start_bad_s = bus.ld_start && !start_ok_s;
  // ready_r is decoded from state only, so the handshake never loops back through ld_valid
  assign hs_s        = bus.ld_valid && ready_r;
  assign last_s      = (10'(ptr_r) + 10'd1) == len_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and error-event decode
  always_comb begin
    next_state_s = state_r;
    err_s        = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start_ok_s) begin
          next_state_s = LOAD;
        end else if (start_bad_s) begin
          err_s = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      LOAD: begin
        if (hs_s && last_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state_s = CHECK;
`else
          next_state_s = DONE;
`endif
        end else begin
          next_state_s = LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (hs_s && (bus.ld_data == xor_r)) begin
          next_state_s = DONE;
        end else if (hs_s) begin
          next_state_s = IDLE;
          err_s        = 1'b1;
        end else begin
          next_state_s = CHECK;
        end
      end
`endif
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the status flags come straight off flops
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    hold_s  = 1'b1;
    case (next_state_s)
      LOAD: begin
        ready_s = 1'b1;
        busy_s  = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        ready_s = 1'b1;
        busy_s  = 1'b1;
      end
`endif
      DONE: begin
        done_s = 1'b1;
        hold_s = 1'b0;
      end
      default: begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        hold_s  = 1'b1;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hold_r  <= 1'b1;
      error_r <= 1'b0;
    end else begin
      ready_r <= ready_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      hold_r  <= hold_s;
      error_r <= err_s;
    end
  end

  // Word pointer and latched program length
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
      len_r <= 10'd0;
    end else if ((state_r == IDLE || state_r == DONE) && start_ok_s) begin
      ptr_r <= '0;
      len_r <= bus.ld_len;
    end else if (state_r == LOAD && hs_s) begin
      ptr_r <= ptr_r + PW'(1);
    end else begin
      ptr_r <= ptr_r;
      len_r <= len_r;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of accepted program words
  always_ff @(posedge clk) begin
    if (reset) begin
      xor_r <= '0;
    end else if ((state_r == IDLE || state_r == DONE) && start_ok_s) begin
      xor_r <= '0;
    end else if (state_r == LOAD && hs_s) begin
      xor_r <= xor_r ^ bus.ld_data;
    end else begin
      xor_r <= xor_r;
    end
  end
`endif

  // IMEM byte writes; contents survive reset, and reset wins over a same-cycle handshake
  always_ff @(posedge clk) begin
    if (!reset && state_r == LOAD && hs_s) begin
      for (int i = 0; i < 4; i++) begin
        mem_r[{ptr_r, 2'(i)}] <= bus.ld_data[8*i +: 8];
      end
    end
  end

  assign rd_base_s = bus.rd_addr[WORD-AW +: AW];
  assign unused_s  = ^bus.rd_addr[0:WORD-AW-1];

  // Fetch read port: each of the eight byte indices wraps modulo the IMEM size
  always_comb begin
    rd_s = '0;
    for (int i = 0; i < 8; i++) begin
      rd_s[8*i +: 8] = mem_r[rd_base_s + AW'(i)];
    end
  end

  assign bus.rd_data    = rd_s;
  assign bus.ld_ready   = ready_r;
  assign bus.ld_busy    = busy_r;
  assign bus.ld_done    = done_r;
  assign bus.ld_error   = error_r;
  assign bus.fetch_hold = hold_r;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load flows, length errors, reset abort, wrap-around reads.
// Also covers the checksum path when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   busy_cnt;
  logic        v_pat [5];
  logic [31:0] d_pat [5];

  imem_loader_if #(.WORD(32)) bus ();

  imem_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input logic [31:0] base);
    logic [31:0] sum;
    sum = 32'h0;
    bus.ld_start = 1'b1;
    bus.ld_len   = 10'(n);
    tick();
    bus.ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = base + 32'(i);
      sum          = sum ^ (base + 32'(i));
      tick();
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    bus.ld_data = sum;
    tick();
`endif
    bus.ld_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.ld_start = 1'b0;
    bus.ld_len   = 10'd0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 32'h0;
    bus.rd_addr  = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy",  64'(bus.ld_busy),    64'd0);
    check("rst_done",  64'(bus.ld_done),    64'd0);
    check("rst_error", 64'(bus.ld_error),   64'd0);
    check("rst_ready", 64'(bus.ld_ready),   64'd0);
    check("rst_hold",  64'(bus.fetch_hold), 64'd1);

    // Rejected lengths: zero and one past capacity
    bus.ld_start = 1'b1;
    bus.ld_len   = 10'd0;
    tick();
    bus.ld_start = 1'b0;
    check("len0_err",   64'(bus.ld_error),   64'd1);
    check("len0_ready", 64'(bus.ld_ready),   64'd0);
    check("len0_hold",  64'(bus.fetch_hold), 64'd1);
    tick();
    check("len0_pulse", 64'(bus.ld_error),   64'd0);
    bus.ld_start = 1'b1;
    bus.ld_len   = 10'd513;
    tick();
    bus.ld_start = 1'b0;
    check("len513_err",   64'(bus.ld_error), 64'd1);
    check("len513_busy",  64'(bus.ld_busy),  64'd0);
    tick();
    check("len513_pulse", 64'(bus.ld_error), 64'd0);
    check("len513_hold",  64'(bus.fetch_hold), 64'd1);

    // Two-word program
    bus.ld_start = 1'b1;
    bus.ld_len   = 10'd2;
    tick();
    bus.ld_start = 1'b0;
    check("p2_ready", 64'(bus.ld_ready), 64'd1);
    check("p2_busy",  64'(bus.ld_busy),  64'd1);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h40200003;
    tick();
    bus.ld_data  = 32'h00200000;
    tick();
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("p2_in_check", 64'(bus.ld_done), 64'd0);
    bus.ld_data  = 32'h40000003;
    tick();
`endif
    bus.ld_valid = 1'b0;
    check("p2_done",  64'(bus.ld_done),    64'd1);
    check("p2_hold",  64'(bus.fetch_hold), 64'd0);
    check("p2_ready_off", 64'(bus.ld_ready), 64'd0);
    bus.rd_addr = 32'd0;
    #1;
    check("p2_rd0", bus.rd_data, 64'h4020000300200000);

    // Reset after two of four words; partial writes stay
    bus.ld_start = 1'b1;
    bus.ld_len   = 10'd4;
    tick();
    bus.ld_start = 1'b0;
    check("ab_hold", 64'(bus.fetch_hold), 64'd1);
    check("ab_done", 64'(bus.ld_done),    64'd0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hAAAA0000;
    tick();
    bus.ld_data  = 32'hAAAA0001;
    tick();
    bus.ld_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ab_rst_hold",  64'(bus.fetch_hold), 64'd1);
    check("ab_rst_done",  64'(bus.ld_done),    64'd0);
    check("ab_rst_ready", 64'(bus.ld_ready),   64'd0);
    bus.rd_addr = 32'd0;
    #1;
    check("ab_partial", bus.rd_data, 64'hAAAA0000AAAA0001);
    load(4, 32'h11111110);
    check("rl_done", 64'(bus.ld_done),    64'd1);
    check("rl_hold", 64'(bus.fetch_hold), 64'd0);
    bus.rd_addr = 32'd0;
    #1;
    check("rl_rd0", bus.rd_data, 64'h1111111011111111);
    bus.rd_addr = 32'd8;
    #1;
    check("rl_rd8", bus.rd_data, 64'h1111111211111113);

    // Three words with ld_valid toggling; a stray ld_start in LOAD is ignored
    v_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    d_pat = '{32'hA1A1A1A1, 32'hDEADBEEF, 32'hB2B2B2B2, 32'hDEADBEEF, 32'hC3C3C3C3};
    busy_cnt = 0;
    bus.ld_start = 1'b1;
    bus.ld_len   = 10'd3;
    tick();
    bus.ld_start = 1'b0;
    if (bus.ld_busy) busy_cnt++;
    for (int k = 0; k < 5; k++) begin
      bus.ld_valid = v_pat[k];
      bus.ld_data  = d_pat[k];
      bus.ld_start = (k == 1);
      bus.ld_len   = 10'd1;
      if (k == 0) begin
        bus.rd_addr = 32'd0;
        #1;
        check("tg_old_read", bus.rd_data, 64'h1111111011111111);
      end
      tick();
      if (bus.ld_busy) busy_cnt++;
    end
    bus.ld_start = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hA1A1A1A1 ^ 32'hB2B2B2B2 ^ 32'hC3C3C3C3;
    tick();
    if (bus.ld_busy) busy_cnt++;
    check("tg_busy_cycles", 64'(busy_cnt), 64'd6);
`else
    check("tg_busy_cycles", 64'(busy_cnt), 64'd5);
`endif
    bus.ld_valid = 1'b0;
    check("tg_done", 64'(bus.ld_done), 64'd1);
    bus.rd_addr = 32'd0;
    #1;
    check("tg_rd0", bus.rd_data, 64'hA1A1A1A1B2B2B2B2);
    bus.rd_addr = 32'd8;
    #1;
    check("tg_rd8", bus.rd_data, 64'hC3C3C3C311111113);

    // Full 512-word program, then wrap-around reads
    load(512, 32'h10000000);
    check("full_done", 64'(bus.ld_done),    64'd1);
    check("full_hold", 64'(bus.fetch_hold), 64'd0);
    bus.rd_addr = 32'd2044;
    #1;
    check("wrap_2044", bus.rd_data, 64'h100001FF10000000);
    bus.rd_addr = 32'd2046;
    #1;
    check("wrap_2046", bus.rd_data, 64'h01FF100000001000);
    bus.rd_addr = 32'd2048;
    #1;
    check("wrap_2048", bus.rd_data, 64'h1000000010000001);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match then mismatch
    load(2, 32'h00000001);
    check("ck_ok_done", 64'(bus.ld_done),    64'd1);
    check("ck_ok_hold", 64'(bus.fetch_hold), 64'd0);
    bus.ld_start = 1'b1;
    bus.ld_len   = 10'd2;
    tick();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h00000001;
    tick();
    bus.ld_data  = 32'h00000002;
    tick();
    bus.ld_data  = 32'h00000004;
    tick();
    bus.ld_valid = 1'b0;
    check("ck_bad_err",   64'(bus.ld_error),   64'd1);
    check("ck_bad_hold",  64'(bus.fetch_hold), 64'd1);
    check("ck_bad_done",  64'(bus.ld_done),    64'd0);
    check("ck_bad_ready", 64'(bus.ld_ready),   64'd0);
    tick();
    check("ck_bad_pulse", 64'(bus.ld_error),   64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory writer and owner of the 2 KB IMEM for the SPU. Accepts a program as a stream of 32-bit words over a valid/ready interface, writes them big-endian into byte-addressed IMEM, and serves the 8-byte fetch read port consumed by instruction fetch. It holds fetch off via `fetch_hold` from reset until a complete program has been loaded.

## Interface
- `WORD`, 32, instruction/data word width in bits
- `IMEM_BYTES`, 2048, IMEM size in bytes; the word capacity is `IMEM_BYTES/4` (512)
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `ld_start`  in  1  one-cycle request to begin a load
- `ld_len`  in  10  number of program words to load, sampled with `ld_start`
- `ld_valid`  in  1  `ld_data` valid
- `ld_data`  in  [0:WORD-1]  program word; bits 0..7 go to the lowest byte address
- `ld_ready`  out  1  loader accepts `ld_data` this cycle
- `ld_busy`  out  1  load in progress
- `ld_done`  out  1  level signal: the last load completed successfully
- `ld_error`  out  1  one-cycle pulse: rejected length or checksum mismatch
- `fetch_hold`  out  1  fetch must keep PC at 0 and must not consume instructions
- `rd_addr`  in  [0:WORD-1]  fetch byte address (PC)
- `rd_data`  out  [0:2*WORD-1]  bytes `rd_addr`..`rd_addr+7`; byte `rd_addr` is in bits 0..7

## Operation
- The FSM has four states: IDLE, LOAD, CHECK (present only with the macro), and DONE.
- **Reset:** state goes to IDLE and the word pointer to 0. Reset values: `ld_busy`=0, `ld_done`=0, `ld_error`=0, `ld_ready`=0, `fetch_hold`=1. IMEM contents are neither cleared nor reset.
- **IDLE:**
  - `ld_start` with 1 ≤ `ld_len` ≤ 512: go to LOAD, latch the length, set the pointer to 0.
  - `ld_start` with `ld_len`=0 or >512: pulse `ld_error` and stay in IDLE.
- **LOAD:**
  - `ld_ready`=1 and `ld_busy`=1.
  - Each handshake (`ld_valid && ld_ready`) writes the word to bytes 4·ptr..4·ptr+3 and increments ptr.
  - On the handshake that accepts word number `len`, go to CHECK (macro on) or DONE (macro off).
  - `ld_start` is ignored.
- **DONE:**
  - `ld_done`=1, `fetch_hold`=0, `ld_ready`=0.
  - `ld_start` starts a reload under the IDLE rules. On a valid start: `ld_done`=0, `fetch_hold`=1, state goes to LOAD.
- **Read port:**
  - Combinational; active in every state.
  - The address is taken modulo `IMEM_BYTES`. Each byte index wraps independently, so `rd_addr`=2044 returns bytes 2044..2047 followed by bytes 0..3.
- **Unloaded bytes:** bytes beyond the loaded length keep their previous contents.
- **`ld_len` width:** values up to 1023 are representable; any value above 512 is an error.

## Timing
- `ld_ready` is a function of state only; it never depends on `ld_valid` combinationally.
- Load throughput is 1 word per cycle. With `ld_valid` held high, an N-word load takes N cycles in LOAD.
- A written byte appears on `rd_data` the cycle after its handshake. Reading the address being written in the same cycle returns the old data.
- `fetch_hold` deasserts, and `ld_done` asserts, in the cycle after the final accepting handshake (the final handshake is the checksum word when the macro is on).
- `ld_error` is high for exactly one cycle, in the cycle after the offending event.
- **Reset mid-load:** the FSM aborts to IDLE, `fetch_hold`=1, and partial writes already made remain in memory.
- **`ld_valid` low in LOAD/CHECK:** the FSM waits indefinitely; there is no timeout.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - The block keeps a running XOR of all accepted program words; it resets to 0 on a valid `ld_start`.
  - After the last program word the FSM enters CHECK with `ld_ready`=1 and accepts exactly one checksum word, which is not written to memory.
  - Match: go to DONE.
  - Mismatch: pulse `ld_error`, go to IDLE, `fetch_hold` stays 1, `ld_done`=0.
- **Undefined:** CHECK and the XOR register are absent; LOAD goes directly to DONE.

## Test plan
- Reset, then load 2 words 0x40200003, 0x00200000 → after completion `fetch_hold`=0, `ld_done`=1; `rd_addr`=0 gives `rd_data`=0x4020000300200000.
- Load 3 words with `ld_valid` toggling 1,0,1,0,1 → exactly 3 writes; `ld_busy` stays high for 5 cycles; no extra write to byte 12.
- `ld_start` with `ld_len`=0, and separately with `ld_len`=513 → a single-cycle `ld_error`, state remains IDLE, `fetch_hold`=1.
- Assert `reset` after 2 of 4 words → `fetch_hold`=1, `ld_done`=0, `ld_ready`=0; a reload of 4 words then completes normally.
- Load 512 words, then read `rd_addr`=2044 → `rd_data` = word 511 followed by word 0 (wrap).
- Macro on: load words 0x1 and 0x2 with checksum 0x3 → DONE. Repeat with checksum 0x4 → `ld_error` pulse, IDLE, `fetch_hold`=1.
